gray_step_sched: RTL and testbench
==================================

// Module: gray_step_sched
// PURPOSE
//   Shares one 3-bit gray-code counter (En/Reset/Overflow interface) between two requesters.
//   Each requester asks for a burst of N count steps.
//   The scheduler arbitrates round-robin, drives the counter's En for exactly N cycles and signals completion.
//   It also sequences counter clears and records which requester's burst caused the first overflow.
//   It sits between the requesting control logic and the gray counter instance.
// PARAMETERS
//   STEP_W   4   width of the step-count inputs; a burst is 0..2**STEP_W-1 steps
// PORTS
//   Clk        in   1       clock, all state updates on posedge
//   Reset_n    in   1       asynchronous, active-low reset
//   Req        in   2       Req[i]=1: requester i wants a burst; held high until Done[i]
//   Steps0     in   STEP_W  burst length for requester 0; sampled only at grant
//   Steps1     in   STEP_W  burst length for requester 1; sampled only at grant
//   Clr_Req    in   1       request a counter clear; held until Clr_Done
//   Gnt        out  2       one-hot grant, high from grant through the DONE cycle
//   Done       out  2       one-cycle pulse on Done[g] when the burst for g ends
//   Clr_Done   out  1       one-cycle pulse when the clear has been issued
//   Cnt_En     out  1       to counter En
//   Cnt_Clr    out  1       to counter Reset (active-high, synchronous at counter)
//   Cnt_Ovf    in   1       from counter Overflow (sticky until counter reset)
//   Ovf_Owner  out  2       one-hot owner of the burst in which Cnt_Ovf first rose; 0 = none
//   Busy       out  1       state != IDLE
// BEHAVIOUR
//   Reset (Reset_n=0, async):
//     - state=IDLE; Gnt, Done, Clr_Done, Ovf_Owner = 0
//     - Remain=0; rr pointer Last=1, so requester 0 wins the first tie
//     - Ovf_q=0; Cnt_En=0, Cnt_Clr=0.
//   States:
//     - IDLE: Clr_Req=1 -> CLR (clear has priority over bursts).
//       Else if any Req -> pick g = round-robin (the requester != Last wins a tie).
//       Set Gnt[g]=1 and Remain=Steps_g.
//       Next state is RUN if Steps_g!=0, else DONE.
//     - RUN: Cnt_En=1 (combinational, state==RUN); Remain decrements each cycle.
//       At Remain==1 -> DONE, so Cnt_En is high exactly Steps_g cycles.
//     - DONE: Cnt_En=0; Done[g]=1 for this cycle only.
//       Next edge: Gnt=0, Last=g, -> IDLE.
//     - CLR: Cnt_Clr=1 and Clr_Done=1 for exactly one cycle.
//       Ovf_Owner=0 and Ovf_q=0 on the next edge, then -> IDLE.
//   Latency: Req sampled at edge k -> Gnt and Cnt_En high after edge k.
//     The counter advances on edges k+1..k+N. Done is high after edge k+N. Gnt falls after edge k+N+1.
//     A back-to-back burst is granted at the earliest edge k+N+2 (one IDLE cycle between bursts).
//   Req/Steps changes while granted are ignored; Steps is latched at grant.
//     A requester still holding Req after Done is re-arbitrated, with round-robin priority going to the other requester.
//   Ovf_Owner: Ovf_q is a registered copy of Cnt_Ovf.
//     If Cnt_Ovf=1, Ovf_q=0, Ovf_Owner==0 and state is RUN or DONE, then Ovf_Owner<=Gnt.
//     Ovf_Owner is sticky until CLR. A rise outside RUN/DONE leaves Ovf_Owner at 0.
//   Clr_Req during RUN waits until the burst completes (DONE -> IDLE -> CLR).
//   Reset mid-burst aborts immediately: Cnt_En drops asynchronously and no Done is issued.
//     Counter position is not restored.
//   Remain is STEP_W bits and never wraps: decrement occurs only in RUN, with Remain>=1.
// TESTING
//   1. Reset, then Req=01, Steps0=3 -> Gnt=01, Cnt_En high 3 cycles, Done=01 one cycle, Busy 4 cycles.
//   2. Req=11 together from reset, Steps0=2, Steps1=1 -> grant order 0 then 1.
//      One IDLE cycle between the bursts; Cnt_En total 3 cycles.
//   3. Req1 held continuously, Req0 re-raised after its Done -> grants alternate 1,0,1 (round-robin fairness).
//   4. Req=01, Steps0=0 -> no Cnt_En, Done=01 one cycle after the grant edge.
//   5. Req=01, Steps0=9 with the counter at 0 -> Cnt_Ovf rises during the burst, Ovf_Owner=01.
//      Then Clr_Req=1 -> Cnt_Clr pulse, Clr_Done pulse, Ovf_Owner=00.
//   6. Reset_n low in the 2nd RUN cycle of a 5-step burst -> Cnt_En=0 and Gnt=00 immediately.
//      No Done; after release the next Req is granted normally.

Source files
------------

// File: rtl/gray_step_sched_if.sv
// gray_step_sched_if
//   Bundles every non-clock signal of the gray-counter burst scheduler.
//   The scheduler connects through the slave modport. The requesters and the
//   gray counter instance connect through the master modport.
//
//   Handshake semantics:
//   - Req[i] acts as "valid". Requester i raises it together with Steps_i and
//     keeps it high until Done[i] pulses.
//   - Gnt[i] is high from the grant edge through the DONE cycle.
//   - Done[i] is the one-cycle completion "ack". The requester may drop Req[i]
//     in the Done cycle. If it keeps Req[i] high after Done, it is
//     re-arbitrated.
//   - Clr_Req and Clr_Done follow the same hold-until-ack rule.
//
//   Signals:
//     Req, Steps0, Steps1, Clr_Req    requester -> scheduler
//     Gnt, Done, Clr_Done             scheduler -> requester
//     Cnt_En, Cnt_Clr                 scheduler -> counter (En, Reset)
//     Cnt_Ovf                         counter -> scheduler (sticky Overflow)
//     Ovf_Owner, Busy                 scheduler status
interface gray_step_sched_if #(
  parameter int STEP_W = 4
);
  logic [1:0]        Req;
  logic [STEP_W-1:0] Steps0;
  logic [STEP_W-1:0] Steps1;
  logic              Clr_Req;
  logic [1:0]        Gnt;
  logic [1:0]        Done;
  logic              Clr_Done;
  logic              Cnt_En;
  logic              Cnt_Clr;
  logic              Cnt_Ovf;
  logic [1:0]        Ovf_Owner;
  logic              Busy;

  modport master (
    output Req, Steps0, Steps1, Clr_Req, Cnt_Ovf,
    input  Gnt, Done, Clr_Done, Cnt_En, Cnt_Clr, Ovf_Owner, Busy
  );

  modport slave (
    input  Req, Steps0, Steps1, Clr_Req, Cnt_Ovf,
    output Gnt, Done, Clr_Done, Cnt_En, Cnt_Clr, Ovf_Owner, Busy
  );
endinterface

// File: rtl/gray_step_sched.sv
// gray_step_sched
//   Shares one 3-bit gray-code counter between two requesters.
//   - Each requester asks for a burst of Steps count steps.
//   - Grants are round-robin. The requester that was not served last wins a
//     tie.
//   - For a granted burst the scheduler drives the counter En for exactly
//     Steps cycles, then pulses Done for that requester.
//   - Counter clears are sequenced here and take priority over new bursts.
//   - The requester whose burst first raised the counter's sticky Overflow is
//     recorded in Ovf_Owner.
//
//   Ports:
//     Clk        clock, all state updates on posedge
//     Reset_n    asynchronous active-low reset; aborts a burst with no Done
//     bus        gray_step_sched_if.slave (see the interface for the signal
//                list and the handshake rules)
//     Dbg_State  current FSM state: 0 IDLE, 1 RUN, 2 DONE, 3 CLR
module gray_step_sched #(
  parameter int STEP_W = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  gray_step_sched_if.slave    bus,
  output logic [1:0]          Dbg_State
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    CLR  = 2'd3
  } state_t;

  localparam logic [STEP_W-1:0] REM_ZERO = '0;
  localparam logic [STEP_W-1:0] REM_ONE  = STEP_W'(1);

  state_t            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [STEP_W-1:0] remain_q, remain_d;
  logic              last_q, last_d;        // index of the last requester served
  logic              ovf_q, ovf_q_d;        // registered copy of Cnt_Ovf
  logic [1:0]        ovf_owner_q, ovf_owner_d;
  logic              pick;                  // index chosen by arbitration
  logic [STEP_W-1:0] steps_sel;

  // State register. Cnt_En is decoded from state_q, so it drops as soon as
  // Reset_n falls.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      remain_q    <= REM_ZERO;
      last_q      <= 1'b1;                  // requester 0 wins the first tie
      ovf_q       <= 1'b0;
      ovf_owner_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      remain_q    <= remain_d;
      last_q      <= last_d;
      ovf_q       <= ovf_q_d;
      ovf_owner_q <= ovf_owner_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    remain_d    = remain_q;
    last_d      = last_q;
    ovf_q_d     = bus.Cnt_Ovf;
    ovf_owner_d = ovf_owner_q;
    pick        = 1'b0;
    steps_sel   = REM_ZERO;

    // Capture the owner only on the first rise of Overflow inside a burst.
    // A rise seen while idle or clearing leaves the owner at "none".
    if (bus.Cnt_Ovf && !ovf_q && (ovf_owner_q == 2'b00) &&
        ((state_q == RUN) || (state_q == DONE))) begin
      ovf_owner_d = gnt_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.Clr_Req) begin
          state_d = CLR;
        end else if (bus.Req != 2'b00) begin
          // On a tie, the requester other than the last one served wins.
          if (bus.Req == 2'b11) pick = ~last_q;
          else                  pick = bus.Req[1];
          steps_sel = pick ? bus.Steps1 : bus.Steps0;
          gnt_d     = pick ? 2'b10 : 2'b01;
          remain_d  = steps_sel;
          state_d   = (steps_sel != REM_ZERO) ? RUN : DONE;
        end
      end
      RUN: begin
        // Remain is at least 1 on entry to RUN. The guard stops any wrap.
        if (remain_q != REM_ZERO) remain_d = remain_q - REM_ONE;
        if (remain_q <= REM_ONE)  state_d  = DONE;
      end
      DONE: begin
        gnt_d   = 2'b00;
        last_d  = gnt_q[1];
        state_d = IDLE;
      end
      CLR: begin
        ovf_owner_d = 2'b00;
        ovf_q_d     = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.Gnt       = gnt_q;
    bus.Done      = (state_q == DONE) ? gnt_q : 2'b00;
    bus.Cnt_En    = (state_q == RUN);
    bus.Cnt_Clr   = (state_q == CLR);
    bus.Clr_Done  = (state_q == CLR);
    bus.Ovf_Owner = ovf_owner_q;
    bus.Busy      = (state_q != IDLE);
    Dbg_State     = state_q;
  end

endmodule

// File: tb/tb_gray_step_sched.sv
module tb_gray_step_sched;

  localparam int W = 6;               // scoreboard entry: {Done[1:0], En cycles[3:0]}

  logic       Clk;
  logic       Reset_n;
  logic [1:0] dbg_state;

  gray_step_sched_if #(.STEP_W(4)) bus();

  gray_step_sched #(.STEP_W(4)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .bus       (bus),
    .Dbg_State (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // 3-bit counter model. Overflow goes high on the wrap from 7 to 0 and stays
  // high until Cnt_Clr.
  logic [2:0] cnt_b;
  logic       cnt_ovf;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_b   <= 3'd0;
      cnt_ovf <= 1'b0;
    end else if (bus.Cnt_Clr) begin
      cnt_b   <= 3'd0;
      cnt_ovf <= 1'b0;
    end else if (bus.Cnt_En) begin
      cnt_b <= cnt_b + 3'd1;
      if (cnt_b == 3'd7) cnt_ovf <= 1'b1;
    end
  end
  assign bus.Cnt_Ovf = cnt_ovf;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int clr_pend = 0;
  int en_cnt   = 0;
  int total_en = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (!Reset_n) begin
        en_cnt   = 0;
        total_en = 0;
      end else begin
        if (bus.Cnt_En) begin
          en_cnt++;
          total_en++;
        end
        if (bus.Done != 2'b00) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", {10'd0, bus.Done, en_cnt[3:0]}, 16'd0);
          end else begin
            e = exp_q.pop_front();
            check("burst_done_en", {10'd0, bus.Done, en_cnt[3:0]}, {10'd0, e});
            check("gnt_at_done", {14'd0, bus.Gnt}, {14'd0, bus.Done});
          end
          en_cnt = 0;
        end
        if (bus.Clr_Done) begin
          check("clr_expected", {15'd0, (clr_pend > 0)}, 16'd1);
          check("cnt_clr_with_clr_done", {15'd0, bus.Cnt_Clr}, 16'd1);
          if (clr_pend > 0) clr_pend--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample_cycles(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    Reset_n     = 1'b0;
    bus.Req     = 2'b00;
    bus.Clr_Req = 1'b0;
    bus.Steps0  = 4'd0;
    bus.Steps1  = 4'd0;
    sample_cycles(2);
    Reset_n = 1'b1;
  endtask

  task automatic push_exp(input logic [1:0] who, input logic [3:0] n);
    exp_q.push_back({who, n});
  endtask

  task automatic wait_done(input int idx, input int bound, output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    do begin
      @(posedge Clk);
      #1;
      cyc++;
      if (bus.Busy) busy_cyc++;
    end while (!bus.Done[idx] && cyc < bound);
    if (!bus.Done[idx]) check("done_timeout", 16'd0, 16'd1);
  endtask

  task automatic wait_clr(input int bound, output int cyc);
    cyc = 0;
    do begin
      @(posedge Clk);
      #1;
      cyc++;
    end while (!bus.Clr_Done && cyc < bound);
    if (!bus.Clr_Done) check("clr_timeout", 16'd0, 16'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, busy;
    Reset_n     = 1'b0;
    bus.Req     = 2'b00;
    bus.Clr_Req = 1'b0;
    bus.Steps0  = 4'd0;
    bus.Steps1  = 4'd0;
    #1;
    check("reset_outputs",
          {3'd0, bus.Gnt, bus.Done, bus.Clr_Done, bus.Cnt_En, bus.Cnt_Clr,
           bus.Ovf_Owner, bus.Busy, dbg_state},
          16'd0);

    // 1: single burst of 3 steps
    apply_reset();
    bus.Req = 2'b01; bus.Steps0 = 4'd3;
    push_exp(2'b01, 4'd3);
    wait_done(0, 20, cyc, busy);
    bus.Req = 2'b00;
    check("t1_done_latency", cyc[15:0], 16'd4);
    check("t1_busy_cycles", busy[15:0], 16'd4);
    sample_cycles(1);
    check("t1_after_done", {12'd0, bus.Gnt, bus.Done}, 16'd0);
    check("t1_idle", {15'd0, bus.Busy}, 16'd0);

    // 2: simultaneous requests, requester 0 wins the first tie
    apply_reset();
    bus.Req = 2'b11; bus.Steps0 = 4'd2; bus.Steps1 = 4'd1;
    push_exp(2'b01, 4'd2);
    push_exp(2'b10, 4'd1);
    wait_done(0, 20, cyc, busy);
    bus.Req[0] = 1'b0;
    check("t2_first_latency", cyc[15:0], 16'd3);
    sample_cycles(1);
    check("t2_gap_idle", {13'd0, bus.Gnt, bus.Busy}, 16'd0);
    sample_cycles(1);
    check("t2_second_gnt", {14'd0, bus.Gnt}, 16'h2);
    wait_done(1, 20, cyc, busy);
    bus.Req[1] = 1'b0;
    check("t2_total_en", total_en[15:0], 16'd3);

    // 3: requester 1 held, requester 0 re-raised -> 1,0,1,0
    apply_reset();
    bus.Req = 2'b10; bus.Steps1 = 4'd2; bus.Steps0 = 4'd1;
    push_exp(2'b10, 4'd2);
    push_exp(2'b01, 4'd1);
    push_exp(2'b10, 4'd2);
    push_exp(2'b01, 4'd1);
    sample_cycles(1);
    bus.Req[0] = 1'b1;
    wait_done(1, 20, cyc, busy);
    wait_done(0, 20, cyc, busy);
    bus.Req[0] = 1'b0;
    sample_cycles(1);
    bus.Req[0] = 1'b1;
    wait_done(1, 20, cyc, busy);
    bus.Req[1] = 1'b0;
    wait_done(0, 20, cyc, busy);
    bus.Req[0] = 1'b0;
    check("t3_queue_drained", exp_q.size(), 16'd0);

    // 4: zero-step burst
    apply_reset();
    bus.Req = 2'b01; bus.Steps0 = 4'd0;
    push_exp(2'b01, 4'd0);
    wait_done(0, 20, cyc, busy);
    bus.Req = 2'b00;
    check("t4_done_latency", cyc[15:0], 16'd1);
    check("t4_no_en", {15'd0, bus.Cnt_En}, 16'd0);

    // 5: overflow ownership, then clear
    apply_reset();
    bus.Req = 2'b01; bus.Steps0 = 4'd9;
    push_exp(2'b01, 4'd9);
    wait_done(0, 30, cyc, busy);
    bus.Req = 2'b00;
    check("t5_ovf_owner", {14'd0, bus.Ovf_Owner}, 16'h1);
    bus.Clr_Req = 1'b1;
    clr_pend++;
    wait_clr(20, cyc);
    bus.Clr_Req = 1'b0;
    sample_cycles(1);
    check("t5_owner_cleared", {14'd0, bus.Ovf_Owner}, 16'd0);
    check("t5_counter_ovf_cleared", {15'd0, bus.Cnt_Ovf}, 16'd0);
    // Clear request and burst request together: the clear goes first
    bus.Clr_Req = 1'b1;
    bus.Req = 2'b01; bus.Steps0 = 4'd1;
    clr_pend++;
    push_exp(2'b01, 4'd1);
    wait_clr(20, cyc);
    bus.Clr_Req = 1'b0;
    check("t5_clr_priority_latency", cyc[15:0], 16'd1);
    wait_done(0, 20, cyc, busy);
    bus.Req = 2'b00;
    check("t5_owner_stays_none", {14'd0, bus.Ovf_Owner}, 16'd0);

    // 6: reset in the 2nd RUN cycle of a 5-step burst
    apply_reset();
    bus.Req = 2'b01; bus.Steps0 = 4'd5;
    sample_cycles(2);
    check("t6_running", {15'd0, bus.Cnt_En}, 16'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("t6_abort", {12'd0, bus.Cnt_En, bus.Busy, bus.Gnt}, 16'd0);
    bus.Req = 2'b00;
    sample_cycles(2);
    Reset_n = 1'b1;
    bus.Req = 2'b01; bus.Steps0 = 4'd2;
    push_exp(2'b01, 4'd2);
    wait_done(0, 20, cyc, busy);
    bus.Req = 2'b00;
    check("t6_regrant_latency", cyc[15:0], 16'd3);

    sample_cycles(3);
    check("final_queue_empty", exp_q.size(), 16'd0);
    check("final_clr_pending", clr_pend[15:0], 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
